// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (1024x768@60 defaults), RGB565 layout and fallback bar palette.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned UCNT_W = 16;

    localparam int unsigned DEF_H_ACTIVE = 1024;
    localparam int unsigned DEF_H_FP     = 24;
    localparam int unsigned DEF_H_SYNC   = 136;
    localparam int unsigned DEF_H_BP     = 160;
    localparam int unsigned DEF_V_ACTIVE = 768;
    localparam int unsigned DEF_V_FP     = 3;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BP     = 29;
    localparam int unsigned DEF_TOGGLE_LEN = 8;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Total line/frame length from its four segments
    function automatic int unsigned seg_total(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        return a + b + c + d;
    endfunction

    // White, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 16'hFFFF;
            3'd1:    bar_colour = 16'hFFE0;
            3'd2:    bar_colour = 16'h07FF;
            3'd3:    bar_colour = 16'h07E0;
            3'd4:    bar_colour = 16'hF81F;
            3'd5:    bar_colour = 16'hF800;
            3'd6:    bar_colour = 16'h001F;
            default: bar_colour = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with stage-0 active/hsync/vsync decode (raw, active-high).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_active_c,
    output logic             o_hs_c,
    output logic             o_vs_c
);

    localparam int unsigned H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;

    // v advances on each h wrap; both wrap together at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    assign o_h_cnt    = r_h_cnt;
    assign o_v_cnt    = r_v_cnt;
    assign o_active_c = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    assign o_hs_c     = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    assign o_vs_c     = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);

endmodule

// File: rtl/vga_frame_reader.sv
// VGA raster + read-FIFO pixel pull with per-frame buffer swap request.
// Define VGA_FALLBACK_BARS_EN to show colour bars instead of black on underrun.
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned TOGGLE_LEN = DEF_TOGGLE_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rdy_to_rd,
    input  logic [15:0]       mem_dout,
    output logic              mem_rd_req,
    output logic              mem_toggle,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [4:0]        vga_r,
    output logic [5:0]        vga_g,
    output logic [4:0]        vga_b,
    output logic [UCNT_W-1:0] underrun_cnt
);

    localparam int unsigned      TOG_W     = $clog2(TOGGLE_LEN);
    localparam logic [CNT_W-1:0] TOG_V_CNT = CNT_W'(V_ACTIVE + V_FP);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;
    logic             w_underrun;
    logic             w_toggle_start;
    rgb565_t          w_pix;

    logic             r_s1_active;
    logic             r_s1_hs;
    logic             r_s1_vs;
    logic             r_s1_got;
    logic [TOG_W-1:0] r_tog_left;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_h_cnt    (w_h_cnt),
        .o_v_cnt    (w_v_cnt),
        .o_active_c (w_active),
        .o_hs_c     (w_hs),
        .o_vs_c     (w_vs)
    );

    // Pop is held off while in reset even though active decodes true at h=v=0
    assign mem_rd_req     = w_active & mem_rdy_to_rd & rst_n;
    assign w_underrun     = w_active & ~mem_rdy_to_rd;
    assign w_toggle_start = (w_h_cnt == '0) && (w_v_cnt == TOG_V_CNT);

    // Swap request: high TOGGLE_LEN clocks from the first vsync line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tog_left <= '0;
            mem_toggle <= 1'b0;
        end else if (w_toggle_start) begin
            r_tog_left <= TOG_W'(TOGGLE_LEN - 1);
            mem_toggle <= 1'b1;
        end else if (r_tog_left != '0) begin
            r_tog_left <= r_tog_left - TOG_W'(1);
            mem_toggle <= 1'b1;
        end else begin
            mem_toggle <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (w_underrun && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + UCNT_W'(1);
        end
    end

    // Stage 1: read data lands alongside these
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_active <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_got    <= 1'b0;
        end else begin
            r_s1_active <= w_active;
            r_s1_hs     <= w_hs;
            r_s1_vs     <= w_vs;
            r_s1_got    <= mem_rd_req;
        end
    end

`ifdef VGA_FALLBACK_BARS_EN
    logic [15:0] r_s1_bar;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_bar <= '0;
        end else begin
            r_s1_bar <= bar_colour(w_h_cnt[9:7]);
        end
    end
`endif

    always_comb begin
        w_pix = '0;
        if (r_s1_got) begin
            w_pix = rgb565_t'(mem_dout);
        end
`ifdef VGA_FALLBACK_BARS_EN
        else if (r_s1_active) begin
            w_pix = rgb565_t'(r_s1_bar);
        end
`endif
    end

    // Stage 2: pin registers, sync converted to pin polarity here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_de <= 1'b0;
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_de <= r_s1_active;
            vga_hs <= r_s1_hs ? SYNC_POL : ~SYNC_POL;
            vga_vs <= r_s1_vs ? SYNC_POL : ~SYNC_POL;
            vga_r  <= w_pix.r;
            vga_g  <= w_pix.g;
            vga_b  <= w_pix.b;
        end
    end

endmodule
